// File: rtl/pcm_conditioner.sv
// PCM conditioner: one-pole DC-blocking high-pass, power-of-two gain with saturation, mute, peak meter, sticky clip.
// Latency 2 cycles from pcm_en to out_en, one sample per cycle; no backpressure (strobe-driven stream).
module pcm_conditioner #(
  parameter int IN_W       = 16,
  parameter int FRAC       = 8,
  parameter int POLE_SHIFT = 8,
  parameter int PEAK_SHIFT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pcm_en,
  input  logic signed [IN_W-1:0] pcm_in,
  input  logic [2:0]             gain_shift,
  input  logic                   mute,
  input  logic                   clip_clr,
  output logic                   out_en,
  output logic signed [IN_W-1:0] pcm_out,
  output logic                   clip,
  output logic [IN_W-2:0]        peak
);

  localparam int D_W = IN_W + 1;
  localparam int Y_W = IN_W + FRAC + 2;
  localparam int A_W = IN_W + FRAC + 3;
  localparam int Q_W = Y_W - FRAC;
  localparam int S_W = Q_W + 7;

  localparam logic [Y_W-1:0]  Y_MAX = {1'b0, {(Y_W-1){1'b1}}};
  localparam logic [Y_W-1:0]  Y_MIN = {1'b1, {(Y_W-1){1'b0}}};
  localparam logic [IN_W-1:0] S_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] S_MIN = {1'b1, {(IN_W-1){1'b0}}};

  logic signed [IN_W-1:0] x_prev;
  logic signed [Y_W-1:0]  y;
  logic                   v1;

  // Stage 1: difference and leaky integration in extended precision
  logic [D_W-1:0]        d;
  logic [A_W-1:0]        d_ext;
  logic signed [A_W-1:0] y_ext;
  logic signed [A_W-1:0] y_dec;
  logic [A_W-1:0]        y_sum;
  logic [Y_W-1:0]        y_sat;

  always_comb begin
    d     = {pcm_in[IN_W-1], pcm_in} - {x_prev[IN_W-1], x_prev};
    d_ext = {{(A_W-D_W){d[D_W-1]}}, d};
    y_ext = {{(A_W-Y_W){y[Y_W-1]}}, y};
    y_dec = y_ext >>> POLE_SHIFT;
    y_sum = (d_ext << FRAC) + y_ext - y_dec;
    if (y_sum[A_W-1] != y_sum[A_W-2])
      y_sat = y_sum[A_W-1] ? Y_MIN : Y_MAX;
    else
      y_sat = y_sum[Y_W-1:0];
  end

  // Stage 2: dropping the fractional bits by slicing is an arithmetic (floor) shift
  logic [Q_W-1:0]       q;
  logic [S_W-1:0]       s;
  logic [S_W-IN_W:0]    s_hi;
  logic                 s_ovf;
  logic [IN_W-1:0]      s_sat;
  logic [IN_W-1:0]      pcm_next;
  logic                 sat_hit;
  logic [IN_W-2:0]      mag;
  logic [IN_W-2:0]      peak_next;

  always_comb begin
    q     = y[Y_W-1:FRAC];
    s     = {{(S_W-Q_W){q[Q_W-1]}}, q} << gain_shift;
    s_hi  = s[S_W-1:IN_W-1];
    s_ovf = !((&s_hi) || (~|s_hi));
    if (s_ovf)
      s_sat = s[S_W-1] ? S_MIN : S_MAX;
    else
      s_sat = s[IN_W-1:0];
    pcm_next = mute ? '0 : s_sat;
    sat_hit  = v1 && !mute && s_ovf;

    if (pcm_next == S_MIN)
      mag = S_MAX[IN_W-2:0];
    else if (pcm_next[IN_W-1])
      mag = ~pcm_next[IN_W-2:0] + 1'b1;
    else
      mag = pcm_next[IN_W-2:0];

    if (mag > peak)
      peak_next = mag;
    else
      peak_next = peak - (peak >> PEAK_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev  <= '0;
      y       <= '0;
      v1      <= 1'b0;
      out_en  <= 1'b0;
      pcm_out <= '0;
      clip    <= 1'b0;
      peak    <= '0;
    end else begin
      v1     <= pcm_en;
      out_en <= v1;
      if (pcm_en) begin
        x_prev <= pcm_in;
        y      <= y_sat;
      end
      if (v1) begin
        pcm_out <= pcm_next;
        peak    <= peak_next;
      end
      clip <= sat_hit || (clip && !clip_clr);
    end
  end

endmodule

// File: tb/tb_pcm_conditioner.sv
// Directed bench for pcm_conditioner: DC step, saturation/clip, negative extreme, back-to-back, mute, reset mid-pipeline.
module tb_pcm_conditioner;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pcm_en = 1'b0;
  logic signed [15:0] pcm_in = '0;
  logic [2:0]         gain_shift = '0;
  logic               mute = 1'b0;
  logic               clip_clr = 1'b0;
  logic               out_en;
  logic signed [15:0] pcm_out;
  logic               clip;
  logic [14:0]        peak;

  int n_chk  = 0;
  int n_fail = 0;

  pcm_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .pcm_en     (pcm_en),
    .pcm_in     (pcm_in),
    .gain_shift (gain_shift),
    .mute       (mute),
    .clip_clr   (clip_clr),
    .out_en     (out_en),
    .pcm_out    (pcm_out),
    .clip       (clip),
    .peak       (peak)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pcm_en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Strobe one sample; returns positioned on the cycle its out_en should be visible.
  task automatic send(input int v);
    pcm_en = 1'b1;
    pcm_in = 16'(v);
    step();
    pcm_en = 1'b0;
    step();
  endtask

  initial begin
    int prev;
    bit mono_ok;

    // Reset values
    step();
    step();
    chk("rst_out_en", {31'd0, out_en}, 0);
    chk("rst_pcm_out", pcm_out, 0);
    chk("rst_clip", {31'd0, clip}, 0);
    chk("rst_peak", {17'd0, peak}, 0);
    rst = 1'b0;

    // 1. DC step of 1000, strobed every 16 cycles
    pcm_en = 1'b1;
    pcm_in = 16'sd1000;
    step();
    pcm_en = 1'b0;
    chk("dc_latency1_out_en", {31'd0, out_en}, 0);
    step();
    chk("dc_first_out_en", {31'd0, out_en}, 1);
    chk("dc_first", pcm_out, 1000);
    step();
    chk("dc_pulse_low", {31'd0, out_en}, 0);
    chk("dc_hold", pcm_out, 1000);
    for (int k = 0; k < 13; k++) step();
    prev = 1000;
    mono_ok = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      send(1000);
      if (!out_en || pcm_out > prev) mono_ok = 1'b0;
      if (i == 1) chk("dc_out2", pcm_out, 996);
      if (i == 2) chk("dc_out3", pcm_out, 992);
      prev = pcm_out;
      for (int k = 0; k < 14; k++) step();
    end
    chk("dc_monotonic", {31'd0, mono_ok}, 1);
    n_chk++;
    assert (prev >= 364 && prev <= 370) else begin
      n_fail++;
      $error("FAIL dc_out257: observed %0d expected 367+-3", prev);
    end
    chk("dc_no_clip", {31'd0, clip}, 0);

    // 2. Saturation and sticky clip
    do_reset();
    gain_shift = 3'd3;
    send(8000);
    chk("sat_out", pcm_out, 32767);
    chk("sat_clip", {31'd0, clip}, 1);
    pcm_en = 1'b1;
    pcm_in = 16'sd8000;
    step();
    pcm_en = 1'b0;
    clip_clr = 1'b1;
    step();
    clip_clr = 1'b0;
    chk("sat_out2", pcm_out, 32767);
    chk("sat_set_beats_clr", {31'd0, clip}, 1);
    clip_clr = 1'b1;
    step();
    clip_clr = 1'b0;
    chk("clip_cleared", {31'd0, clip}, 0);
    gain_shift = 3'd0;

    // 3. Negative extreme
    do_reset();
    send(-32768);
    chk("neg_out", pcm_out, -32768);
    chk("neg_peak", {17'd0, peak}, 32767);
    chk("neg_no_clip", {31'd0, clip}, 0);

    // 4. Back-to-back strobes on a ramp
    do_reset();
    pcm_en = 1'b1;
    pcm_in = 16'sd100;
    step();
    chk("b2b_lat", {31'd0, out_en}, 0);
    pcm_in = 16'sd200;
    step();
    chk("b2b_en0", {31'd0, out_en}, 1);
    chk("b2b_out0", pcm_out, 100);
    pcm_in = 16'sd300;
    step();
    chk("b2b_en1", {31'd0, out_en}, 1);
    chk("b2b_out1", pcm_out, 199);
    pcm_in = 16'sd400;
    step();
    chk("b2b_en2", {31'd0, out_en}, 1);
    chk("b2b_out2", pcm_out, 298);
    pcm_en = 1'b0;
    step();
    chk("b2b_en3", {31'd0, out_en}, 1);
    chk("b2b_out3", pcm_out, 397);
    step();
    chk("b2b_end", {31'd0, out_en}, 0);

    // 5. Mute keeps the filter running and lets peak decay
    do_reset();
    send(1000);
    chk("mute_pre_peak", {17'd0, peak}, 1000);
    mute = 1'b1;
    send(1000);
    chk("mute_out", pcm_out, 0);
    chk("mute_peak1", {17'd0, peak}, 938);
    send(1000);
    chk("mute_peak2", {17'd0, peak}, 880);
    chk("mute_no_clip", {31'd0, clip}, 0);
    mute = 1'b0;
    send(1000);
    chk("unmute_out", pcm_out, 988);
    chk("unmute_peak", {17'd0, peak}, 988);

    // 6. Reset while a sample is in flight
    pcm_en = 1'b1;
    pcm_in = 16'sd700;
    step();
    pcm_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_mid_no_out_en", {31'd0, out_en}, 0);
    end
    chk("rst_mid_pcm_out", pcm_out, 0);
    chk("rst_mid_peak", {17'd0, peak}, 0);
    chk("rst_mid_clip", {31'd0, clip}, 0);
    send(500);
    chk("rst_mid_next_en", {31'd0, out_en}, 1);
    chk("rst_mid_next", pcm_out, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
